// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Stalls the pipeline while busy and presents {hi,lo} with a one-cycle done pulse.
module muldiv_seq #(
  parameter int MUL_LAT  = 3,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = ($clog2(MUL_LAT) > 5) ? $clog2(MUL_LAT) : 5;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] count;
  logic             accept, isSigned, mulLoad, divLoad;

  // Division working registers: divQ shifts the dividend out and the quotient in.
  logic [31:0] divQ, divB, rem;
  logic        signQ, signR;

  assign accept   = start & ~flush & ((state == IDLE) | (state == DONE));
  assign isSigned = ~op[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // NOTE: default assignment first, so no path through this block infers a latch.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) stateNext = op[1] ? DIV : ((MUL_LAT == 1) ? DONE : MUL);
        else        stateNext = IDLE;
      end
      MUL:     if (count == MUL_LAST) stateNext = DONE;
      DIV:     if (count == DIV_LAST) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = IDLE;
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE:     stall = accept;
      DONE: begin
        stall = accept;
        done  = ~flush;
      end
      MUL, DIV: stall = 1'b1;
      default: ;
    endcase
  end

  // Multiplier: sign- or zero-extend to 64 bits so one unsigned multiply serves both ops.
  logic [63:0] mulA, mulB, mulNow, mulResult;
  assign mulA   = {{32{isSigned & a[31]}}, a};
  assign mulB   = {{32{isSigned & b[31]}}, b};
  assign mulNow = mulA * mulB;

  if (MUL_LAT == 1) begin : g_mulDirect
    assign mulResult = mulNow;
  end else begin : g_mulPipe
    logic [63:0] prodPipe [MUL_LAT-1];

    // NOTE: the pipeline array is reset like any other register so that no
    // X can ever reach hi/lo, even though its contents are gated by state.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < MUL_LAT - 1; i++) prodPipe[i] <= '0;
      end else begin
        if (accept && !op[1]) prodPipe[0] <= mulNow;
        for (int i = 1; i < MUL_LAT - 1; i++) prodPipe[i] <= prodPipe[i-1];
      end
    end

    assign mulResult = prodPipe[MUL_LAT-2];
  end

  assign mulLoad = (MUL_LAT == 1) ? (accept & ~op[1])
                                  : ((state == MUL) & (count == MUL_LAST) & ~flush);
  assign divLoad = (state == DIV) & (count == DIV_LAST) & ~flush;

  // One restoring step: the 33-bit partial remainder is compared against the divisor.
  logic [32:0] remShift;
  logic [31:0] remNext, qNext, absA, absB;
  logic        qBit;

  always_comb begin
    remShift = {rem, divQ[31]};
    qBit     = remShift >= {1'b0, divB};
    remNext  = qBit ? (remShift[31:0] - divB) : remShift[31:0];
    qNext    = {divQ[30:0], qBit};
  end

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign absA = (isSigned & a[31]) ? -a : a;
  assign absB = (isSigned & b[31]) ? -b : b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      divQ  <= '0;
      divB  <= '0;
      rem   <= '0;
      signQ <= 1'b0;
      signR <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        count <= '0;
        if (op[1]) begin
          divQ  <= absA;
          divB  <= absB;
          rem   <= '0;
          signQ <= isSigned & (a[31] ^ b[31]);
          signR <= isSigned & a[31];
        end
      end else if (state == MUL || state == DIV) begin
        count <= count + CNT_W'(1);
        if (state == DIV) begin
          divQ <= qNext;
          rem  <= remNext;
        end
      end

      if (mulLoad) begin
        {hi, lo} <= mulResult;
      end else if (divLoad) begin
        hi <= signR ? -remNext : remNext;
        lo <= signQ ? -qNext : qNext;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, flush, back-to-back and reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.MUL_LAT(3), .DIV_ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle T and checks stall/done every cycle up to T+lat.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int lat, input logic [63:0] expRes);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check({tag, " stall at T"}, stall, 1'b1);
    tick();
    start = 1'b0;
    #1;
    for (int i = 1; i < lat; i++) begin
      check({tag, " busy"}, {stall, done}, 2'b10);
      tick();
    end
    check({tag, " done"}, {stall, done}, 2'b01);
    check({tag, " result"}, {hi, lo}, expRes);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    #12;
    check("reset outputs", {stall, done, hi, lo}, '0);
    tick();
    resetn = 1'b1;
    tick();

    runOp("mult -2*3", 2'b00, 32'hFFFFFFFE, 32'd3, 3, 64'hFFFFFFFF_FFFFFFFA);
    tick();
    check("mult done one cycle", {stall, done}, 2'b00);
    check("mult hold", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    runOp("multu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 64'hFFFFFFFE_00000001);
    tick();
    runOp("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);
    tick();
    runOp("divu 100/0", 2'b11, 32'd100, 32'd0, 33, 64'h00000064_FFFFFFFF);
    tick();
    runOp("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
    tick();
    runOp("div -5/0", 2'b10, 32'hFFFFFFFB, 32'd0, 33, 64'hFFFFFFFB_00000001);
    tick();
    runOp("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    tick();

    // Back-to-back: the DIVU is started in the MULTU DONE cycle.
    runOp("multu 5*6", 2'b01, 32'd5, 32'd6, 3, 64'h00000000_0000001E);
    runOp("divu 30/4 b2b", 2'b11, 32'd30, 32'd4, 33, 64'h00000002_00000007);
    tick();

    // Flush at T+10 of a DIV.
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    #1;
    check("flush div stall at T", stall, 1'b1);
    tick();
    start = 1'b0;
    #1;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    check("flush cycle stall", stall, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    check("after flush idle", {stall, done}, 2'b00);
    for (int i = 0; i < 30; i++) begin
      check("after flush no done", done, 1'b0);
      tick();
    end
    check("flush keeps hi/lo", {hi, lo}, 64'h00000002_00000007);

    // Flush together with start: start dropped.
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    #1;
    check("flush+start stall", stall, 1'b0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush+start idle", {stall, done}, 2'b00);
    tick();
    tick();
    check("flush+start no result", {stall, done, hi, lo}, {2'b00, 64'h00000002_00000007});

    // Start during DIV is ignored and not queued.
    start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd8;
    #1;
    tick();
    start = 1'b0;
    #1;
    for (int i = 1; i < 33; i++) begin
      start = (i == 5);
      op = 2'b01; a = 32'd9; b = 32'd9;
      #1;
      check("ignored start busy", {stall, done}, 2'b10);
      tick();
    end
    start = 1'b0;
    #1;
    check("ignored start done", {stall, done}, 2'b01);
    check("ignored start result", {hi, lo}, 64'h00000002_00000006);
    tick();
    check("no queued op", {stall, done}, 2'b00);

    // Async reset in the middle of a DIV.
    start = 1'b1; op = 2'b11; a = 32'd30; b = 32'd4;
    #1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    check("mid-div reset", {stall, done, hi, lo}, '0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 35; i++) begin
      check("after reset no done", {stall, done}, 2'b00);
      tick();
    end

    runOp("mult 7*-5", 2'b00, 32'd7, 32'hFFFFFFFB, 3, 64'hFFFFFFFF_FFFFFFDD);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
